mem_arbiter: RTL and testbench

Two-port arbiter that shares the single-port `Memoria` between the CPU datapath (the `IorD`-selected fetch/data access) and a debug/loader port. It owns the memory's address, write-enable and write-data pins. It sequences each access through a fixed multi-cycle read/write schedule and returns data plus a one-cycle acknowledge to the winning requester. It sits between the `UP` datapath and `Memoria`; the CPU control unit holds its state until `Cpu_ack`.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arb_starve_cnt.sv | 31 +++
 rtl/mem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared state type, port IDs and default widths for mem_arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF     = 32;
  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned STARVE_MAX_DEF = 4;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Saturating count of CPU grants that bypassed a waiting debug request.
// Only present in builds with MEM_ARB_STARVE_EN defined.
`ifdef MEM_ARB_STARVE_EN
module mem_arb_starve_cnt #(
  parameter int unsigned CNT_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic hit_c
);

  localparam int unsigned CNT_W = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != CNT_W'(CNT_MAX))) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign hit_c = (cnt_q == CNT_W'(CNT_MAX));

endmodule
`endif

// File: rtl/mem_arbiter.sv
// Two-port (CPU / debug) arbiter sequencing single-port memory accesses IDLE->ACCESS->WAIT->DONE.
// Define MEM_ARB_STARVE_EN to let debug win after STARVE_MAX consecutive CPU grants.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Cpu_req,
  input  logic              Cpu_wr,
  input  logic [ADDR_W-1:0] Cpu_addr,
  input  logic [DATA_W-1:0] Cpu_wdata,
  output logic              Cpu_ack,
  output logic [DATA_W-1:0] Cpu_rdata,
  input  logic              Dbg_req,
  input  logic              Dbg_wr,
  input  logic [ADDR_W-1:0] Dbg_addr,
  input  logic [DATA_W-1:0] Dbg_wdata,
  output logic              Dbg_ack,
  output logic [DATA_W-1:0] Dbg_rdata,
  output logic [ADDR_W-1:0] Mem_addr,
  output logic              Mem_wr,
  output logic [DATA_W-1:0] Mem_wdata,
  input  logic [DATA_W-1:0] Mem_rdata,
  output logic              Owner,
  output logic              Busy
);

  arb_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_wr_q, mem_wr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              dbg_ack_q, dbg_ack_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic              cpu_grant_c, dbg_grant_c, starve_hit_c;

`ifdef MEM_ARB_STARVE_EN
  // A CPU grant with debug idle also restarts the count.
  mem_arb_starve_cnt #(
    .CNT_MAX (STARVE_MAX)
  ) u_starve_cnt (
    .clk   (Clk),
    .rst_n (Reset),
    .inc   (cpu_grant_c && Dbg_req),
    .clr   (dbg_grant_c || (cpu_grant_c && !Dbg_req)),
    .hit_c (starve_hit_c)
  );
`else
  logic starve_unused;
  assign starve_hit_c  = 1'b0;
  assign starve_unused = (STARVE_MAX != 0) | cpu_grant_c | dbg_grant_c;
`endif

  // Next-state and next-output decode; memory pins and acks come straight from flops.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wr_d        = wr_q;
    wdata_d     = wdata_q;
    owner_d     = owner_q;
    mem_addr_d  = '0;
    mem_wr_d    = 1'b0;
    mem_wdata_d = '0;
    cpu_ack_d   = 1'b0;
    dbg_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    cpu_grant_c = 1'b0;
    dbg_grant_c = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (Cpu_req || Dbg_req) begin
          state_d = ACCESS;
          if (Dbg_req && (!Cpu_req || starve_hit_c)) begin
            dbg_grant_c = 1'b1;
            owner_d     = PORT_DBG;
            addr_d      = Dbg_addr;
            wr_d        = Dbg_wr;
            wdata_d     = Dbg_wdata;
          end else begin
            cpu_grant_c = 1'b1;
            owner_d     = PORT_CPU;
            addr_d      = Cpu_addr;
            wr_d        = Cpu_wr;
            wdata_d     = Cpu_wdata;
          end
          mem_addr_d  = addr_d;
          mem_wr_d    = wr_d;
          mem_wdata_d = wdata_d;
        end
      end
      ACCESS: begin
        state_d    = WAIT;
        mem_addr_d = addr_q;
      end
      WAIT: begin
        state_d    = DONE;
        mem_addr_d = addr_q;
        cpu_ack_d  = (owner_q == PORT_CPU);
        dbg_ack_d  = (owner_q == PORT_DBG);
      end
      DONE: begin
        state_d = IDLE;
        if (!wr_q) begin
          if (owner_q == PORT_DBG) dbg_rdata_d = Mem_rdata;
          else                     cpu_rdata_d = Mem_rdata;
        end
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
      owner_q     <= PORT_CPU;
      mem_addr_q  <= '0;
      mem_wr_q    <= 1'b0;
      mem_wdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      dbg_ack_q   <= 1'b0;
      busy_q      <= 1'b0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wr_q        <= wr_d;
      wdata_q     <= wdata_d;
      owner_q     <= owner_d;
      mem_addr_q  <= mem_addr_d;
      mem_wr_q    <= mem_wr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_ack_q   <= cpu_ack_d;
      dbg_ack_q   <= dbg_ack_d;
      busy_q      <= busy_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  assign Mem_addr  = mem_addr_q;
  assign Mem_wr    = mem_wr_q;
  assign Mem_wdata = mem_wdata_q;
  assign Cpu_ack   = cpu_ack_q;
  assign Dbg_ack   = dbg_ack_q;
  assign Cpu_rdata = cpu_rdata_q;
  assign Dbg_rdata = dbg_rdata_q;
  assign Owner     = owner_q;
  assign Busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_mem_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          cpu_req = 1'b0, cpu_wr = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          dbg_req = 1'b0, dbg_wr = 1'b0;
  logic [AW-1:0] dbg_addr = '0;
  logic [DW-1:0] dbg_wdata = '0;
  logic          cpu_ack, dbg_ack, mem_wr, owner, busy;
  logic [DW-1:0] cpu_rdata, dbg_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .Clk(clk), .Reset(rst_n),
    .Cpu_req(cpu_req), .Cpu_wr(cpu_wr), .Cpu_addr(cpu_addr), .Cpu_wdata(cpu_wdata),
    .Cpu_ack(cpu_ack), .Cpu_rdata(cpu_rdata),
    .Dbg_req(dbg_req), .Dbg_wr(dbg_wr), .Dbg_addr(dbg_addr), .Dbg_wdata(dbg_wdata),
    .Dbg_ack(dbg_ack), .Dbg_rdata(dbg_rdata),
    .Mem_addr(mem_addr), .Mem_wr(mem_wr), .Mem_wdata(mem_wdata), .Mem_rdata(mem_rdata),
    .Owner(owner), .Busy(busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_mid(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [DW-1:0] init_word(input int i);
    case (i)
      'h10:    return 32'hDEADBEEF;
      'h30:    return 32'h0BADF00D;
      'h40:    return 32'hA5A5A5A5;
      'h50:    return 32'h11111111;
      'h60:    return 32'h600DCAFE;
      default: return DW'(i) * 32'h9E3779B9 + 32'h1234;
    endcase
  endfunction

  // Memory: write on the ACCESS edge, registered read so data is valid two edges after the address.
  logic [DW-1:0] mem [256];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (mem_wr) mem[mem_addr[7:0]] = mem_wdata;
      mem_rdata <= mem[mem_addr[7:0]];
    end
  end

  // Transaction-level model: a grant opens a transaction whose outputs depend only on cycles since grant.
  int            cyc, t_start, m_cnt;
  bit            m_active, m_owner, t_port, t_wr;
  logic [AW-1:0] t_addr;
  logic [DW-1:0] t_wdata, m_cpu_rd, m_dbg_rd;
  logic [DW-1:0] ref_mem [256];

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    cyc = 0; t_start = 0; m_cnt = 0; m_active = 0; m_owner = 0;
    t_port = 0; t_wr = 0; t_addr = '0; t_wdata = '0; m_cpu_rd = '0; m_dbg_rd = '0;
    forever begin
      bit starve;
      int off;
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_active = 0; m_owner = 0; m_cnt = 0; m_cpu_rd = '0; m_dbg_rd = '0;
      end else begin
        if (m_active) begin
          off = cyc - t_start;
          if (off == 1 && t_wr) ref_mem[t_addr[7:0]] = t_wdata;
          if (off == 3) begin
            if (!t_wr) begin
              if (t_port) m_dbg_rd = ref_mem[t_addr[7:0]];
              else        m_cpu_rd = ref_mem[t_addr[7:0]];
            end
            m_active = 0;
          end
        end else if (cpu_req || dbg_req) begin
          starve = 0;
`ifdef MEM_ARB_STARVE_EN
          starve = (m_cnt == SMAX);
`endif
          if (dbg_req && (!cpu_req || starve)) begin
            t_port = 1; t_wr = dbg_wr; t_addr = dbg_addr; t_wdata = dbg_wdata;
            m_cnt = 0;
          end else begin
            t_port = 0; t_wr = cpu_wr; t_addr = cpu_addr; t_wdata = cpu_wdata;
            m_cnt = dbg_req ? ((m_cnt < SMAX) ? m_cnt + 1 : m_cnt) : 0;
          end
          m_owner  = t_port;
          m_active = 1;
          t_start  = cyc;
        end
        cyc++;
      end
    end
  end

  // Per-cycle comparison of every output against the model, sampled mid-cycle.
  always @(negedge clk) begin
    int off;
    off = cyc - t_start;
    chk("busy", 32'(busy), 32'(m_active));
    chk("mem_wr", 32'(mem_wr), 32'(m_active && off == 1 && t_wr));
    if (!m_active) begin
      chk("mem_addr_idle", mem_addr, 32'd0);
      chk("mem_wdata_idle", mem_wdata, 32'd0);
    end else if (off == 1) begin
      chk("mem_addr_access", mem_addr, t_addr);
      chk("mem_wdata_access", mem_wdata, t_wdata);
    end else if (off == 2) begin
      chk("mem_addr_wait", mem_addr, t_addr);
    end
    chk("cpu_ack", 32'(cpu_ack), 32'(m_active && off == 3 && !t_port));
    chk("dbg_ack", 32'(dbg_ack), 32'(m_active && off == 3 && t_port));
    chk("owner", 32'(owner), 32'(m_owner));
    chk("cpu_rdata", cpu_rdata, m_cpu_rd);
    chk("dbg_rdata", dbg_rdata, m_dbg_rd);
  end

  initial begin
    #1 rst_n = 1'b0;
    wait_mid(2);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("rst_dbg_ack", 32'(dbg_ack), 32'd0);

    // CPU read of 0x10
    @(posedge clk); #1;
    rst_n = 1'b1; cpu_req = 1; cpu_wr = 0; cpu_addr = 32'h10;
    wait_mid(2); chk("a_addr_c1", mem_addr, 32'h10);
    wait_mid(1); chk("a_addr_c2", mem_addr, 32'h10);
    wait_mid(1); chk("a_ack_c3", 32'(cpu_ack), 32'd1);
    @(posedge clk); #1; cpu_req = 0;
    wait_mid(1); chk("a_rdata", cpu_rdata, 32'hDEADBEEF);

    // CPU write 0x20 then read back
    @(posedge clk); #1;
    cpu_req = 1; cpu_wr = 1; cpu_addr = 32'h20; cpu_wdata = 32'h12345678;
    wait_mid(2); chk("b_wr_c1", 32'(mem_wr), 32'd1); chk("b_wdata_c1", mem_wdata, 32'h12345678);
    wait_mid(1); chk("b_wr_c2", 32'(mem_wr), 32'd0);
    wait_mid(1); chk("b_ack_c3", 32'(cpu_ack), 32'd1);
    @(posedge clk); #1; cpu_wr = 0;
    wait_mid(1); chk("b_rdata_kept", cpu_rdata, 32'hDEADBEEF);
    wait_mid(3); chk("b_rd_ack", 32'(cpu_ack), 32'd1);
    @(posedge clk); #1; cpu_req = 0;
    wait_mid(1); chk("b_readback", cpu_rdata, 32'h12345678);

    // Debug read with CPU idle
    @(posedge clk); #1;
    dbg_req = 1; dbg_wr = 0; dbg_addr = 32'h40;
    wait_mid(4); chk("f_dbg_ack", 32'(dbg_ack), 32'd1); chk("f_cpu_ack", 32'(cpu_ack), 32'd0);
    @(posedge clk); #1; dbg_req = 0;
    wait_mid(1); chk("f_dbg_rdata", dbg_rdata, 32'hA5A5A5A5); chk("f_cpu_kept", cpu_rdata, 32'h12345678);

    // Simultaneous requests: CPU first, then debug
    @(posedge clk); #1;
    cpu_req = 1; cpu_wr = 0; cpu_addr = 32'h30;
    dbg_req = 1; dbg_wr = 0; dbg_addr = 32'h60;
    wait_mid(4); chk("c_cpu_ack", 32'(cpu_ack), 32'd1); chk("c_dbg_ack_c3", 32'(dbg_ack), 32'd0);
    @(posedge clk); #1; cpu_req = 0;
    wait_mid(2); chk("c_owner_c5", 32'(owner), 32'd1);
    wait_mid(2); chk("c_dbg_ack_c7", 32'(dbg_ack), 32'd1); chk("c_owner_c7", 32'(owner), 32'd1);
    @(posedge clk); #1; dbg_req = 0;
    wait_mid(1); chk("c_dbg_rdata", dbg_rdata, 32'h600DCAFE); chk("c_cpu_rdata", cpu_rdata, 32'h0BADF00D);

    // Both ports held high: fifth grant decides starvation behaviour
    @(posedge clk); #1;
    cpu_req = 1; cpu_addr = 32'h10; dbg_req = 1; dbg_addr = 32'h40;
    wait_mid(20);
`ifdef MEM_ARB_STARVE_EN
    chk("d_dbg_ack_c19", 32'(dbg_ack), 32'd1); chk("d_cpu_ack_c19", 32'(cpu_ack), 32'd0);
`else
    chk("d_dbg_ack_c19", 32'(dbg_ack), 32'd0); chk("d_cpu_ack_c19", 32'(cpu_ack), 32'd1);
`endif
    @(posedge clk); #1; cpu_req = 0; dbg_req = 0;

    // Reset during the ACCESS cycle of a write
    @(posedge clk); #1;
    cpu_req = 1; cpu_wr = 1; cpu_addr = 32'h50; cpu_wdata = 32'hCAFEF00D;
    wait_mid(2); chk("e_wr_c1", 32'(mem_wr), 32'd1);
    #2 rst_n = 1'b0; cpu_req = 0;
    #1;
    chk("e_mem_wr", 32'(mem_wr), 32'd0); chk("e_busy", 32'(busy), 32'd0);
    chk("e_mem_addr", mem_addr, 32'd0); chk("e_cpu_rdata", cpu_rdata, 32'd0);
    chk("e_dbg_rdata", dbg_rdata, 32'd0); chk("e_cpu_ack", 32'(cpu_ack), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; cpu_req = 1; cpu_wr = 0; cpu_addr = 32'h50;
    wait_mid(4); chk("e_ack_c3", 32'(cpu_ack), 32'd1);
    @(posedge clk); #1; cpu_req = 0;
    wait_mid(1); chk("e_write_lost", cpu_rdata, 32'h11111111);

    // Random traffic with occasional asynchronous resets
    for (int n = 0; n < 1200; n++) begin
      @(posedge clk); #1;
      cpu_req   = ($urandom_range(0, 7) < (((n / 200) % 2 == 1) ? 7 : 3));
      cpu_wr    = $urandom_range(0, 1) == 1;
      cpu_addr  = 32'($urandom_range(0, 255));
      cpu_wdata = $urandom;
      dbg_req   = $urandom_range(0, 1) == 1;
      dbg_wr    = $urandom_range(0, 1) == 1;
      dbg_addr  = 32'($urandom_range(0, 255));
      dbg_wdata = $urandom;
      if ($urandom_range(0, 99) == 0) begin
        #3 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
      end
    end
    cpu_req = 0; dbg_req = 0;
    wait_mid(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
